// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - load/store unit bus master (req/gnt/rvalid data bus).
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them.
module lsu_bus_master #(
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          memrd_i,
  input  logic          memw_i,
  input  logic [2:0]    funct3_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic          stall_o,
  output logic [31:0]   rdata_o,
  output logic          misalign_o,
  output logic          data_req_o,
  output logic          data_we_o,
  output logic [AW-1:0] data_addr_o,
  output logic [3:0]    data_be_o,
  output logic [31:0]   data_wdata_o,
  input  logic          data_gnt_i,
  input  logic          data_rvalid_i,
  input  logic [31:0]   data_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic          misal_q, misal_d;
  logic          misal_new;
`endif

  logic          req_new;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_fmt;

  assign req_new = memrd_i | memw_i;

  // Lane placement is decided once, at acceptance, so the bus fields stay stable in REQ.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_new = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal_new = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     (funct3_i[1] && (addr_i[1:0] != 2'b00));
`endif

  always_comb begin
    ld_byte = data_rdata_i[7:0];
    case (addr_q[1:0])
      2'b01:   ld_byte = data_rdata_i[15:8];
      2'b10:   ld_byte = data_rdata_i[23:16];
      2'b11:   ld_byte = data_rdata_i[31:24];
      default: ;
    endcase
    ld_half = addr_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (funct3_q[1:0])
      2'b00:   ld_fmt = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
      default: ld_fmt = data_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    misal_d    = misal_q;
`endif
    stall_o    = 1'b0;
    data_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = req_new;
        if (req_new) begin
          we_d     = memw_i;
          addr_d   = addr_i;
          funct3_d = funct3_i;
          be_d     = be_new;
          wdata_d  = wdata_new;
          state_d  = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
          misal_d  = misal_new;
          if (misal_new) state_d = DONE;
`endif
        end
      end
      REQ: begin
        stall_o    = 1'b1;
        data_req_o = 1'b1;
        if (data_gnt_i) begin
          if (we_q) begin
            state_d = DONE;
          end else if (data_rvalid_i) begin
            rdata_d = ld_fmt;
            state_d = DONE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        stall_o = 1'b1;
        if (data_rvalid_i) begin
          rdata_d = ld_fmt;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      funct3_q <= 3'b000;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      misal_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misal_q  <= misal_d;
`endif
    end
  end

  assign data_we_o    = we_q;
  assign data_addr_o  = {addr_q[AW-1:2], 2'b00};
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o = (state_q == DONE) && misal_q;
  assign rdata_o    = misalign_o ? 32'h0 : rdata_q;
`else
  assign misalign_o = 1'b0;
  assign rdata_o    = rdata_q;
`endif

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb/tb_lsu_bus_master.sv - randomized and directed bench for lsu_bus_master.
// Expectations follow LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        memrd_i = 1'b0;
  logic        memw_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        misalign_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [31:0] data_addr_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'h0;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rdata = 32'h0;

  always #5 clk = ~clk;

  lsu_bus_master #(.AW(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .memrd_i(memrd_i), .memw_i(memw_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .misalign_o(misalign_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes, then lane offset/mask arithmetic.
  function automatic int unsigned acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (a % acc_size(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned lane_off(input logic [2:0] f3, input logic [31:0] a);
    int unsigned o = a % 4;
    return o - (o % acc_size(f3));
  endfunction

  function automatic logic [31:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned v = ((1 << acc_size(f3)) - 1) << lane_off(f3, a);
    return v;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (acc_size(f3) == 1) return (w & 32'hFF) * 32'h01010101;
    if (acc_size(f3) == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned sz = acc_size(f3);
    logic [31:0] v = rd >> (8 * lane_off(f3, a));
    logic [31:0] mask;
    if (sz == 4) return v;
    mask = (32'd1 << (8 * sz)) - 1;
    v = v & mask;
    if (!f3[2] && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~mask;
    return v;
  endfunction

  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] w,
                           input int gd, input int rvd, input logic [31:0] bus_rd);
    logic [31:0] exp;
    memrd_i = rd; memw_i = wr; funct3_i = f3; addr_i = a; wdata_i = w;
    #1;
    check("idle_stall", {31'h0, stall_o}, 32'h1);
    if (is_misaligned(f3, a)) begin
      @(posedge clk); #1;
      check("mis_req", {31'h0, data_req_o}, 32'h0);
      check("mis_flag", {31'h0, misalign_o}, 32'h1);
      check("mis_rdata", rdata_o, 32'h0);
      check("mis_stall", {31'h0, stall_o}, 32'h0);
    end else begin
      for (int c = 0; c <= gd; c++) begin
        @(posedge clk); #1;
        check("req_req", {31'h0, data_req_o}, 32'h1);
        check("req_stall", {31'h0, stall_o}, 32'h1);
        check("req_we", {31'h0, data_we_o}, {31'h0, wr});
        check("req_addr", data_addr_o, a & 32'hFFFF_FFFC);
        check("req_be", {28'h0, data_be_o}, exp_be(f3, a));
        if (wr) check("req_wdata", data_wdata_o, exp_wdata(f3, w));
        if (c == gd) begin
          data_gnt_i = 1'b1;
          if (!wr && rvd == 0) begin data_rvalid_i = 1'b1; data_rdata_i = bus_rd; end
        end
      end
      if (!wr) begin
        for (int k = 1; k <= rvd; k++) begin
          @(posedge clk); #1;
          data_gnt_i = 1'b0;
          data_rdata_i = $urandom;
          check("resp_stall", {31'h0, stall_o}, 32'h1);
          check("resp_req", {31'h0, data_req_o}, 32'h0);
          if (k == rvd) begin data_rvalid_i = 1'b1; data_rdata_i = bus_rd; end
        end
      end
      @(posedge clk); #1;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = $urandom;
      check("done_stall", {31'h0, stall_o}, 32'h0);
      check("done_misal", {31'h0, misalign_o}, 32'h0);
      if (wr) begin
        check("done_st_rdata", rdata_o, last_rdata);
      end else begin
        exp = exp_load(f3, a, bus_rd);
        check("done_ld_rdata", rdata_o, exp);
        last_rdata = exp;
      end
    end
    // Request still held through DONE; it must not be re-accepted there.
    memrd_i = 1'b0; memw_i = 1'b0;
    @(posedge clk); #1;
    check("after_req", {31'h0, data_req_o}, 32'h0);
    check("after_stall", {31'h0, stall_o}, 32'h0);
    check("after_misal", {31'h0, misalign_o}, 32'h0);
  endtask

  initial begin
    int sel;
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {31'h0, data_req_o}, 32'h0);
    check("rst_we", {31'h0, data_we_o}, 32'h0);
    check("rst_addr", data_addr_o, 32'h0);
    check("rst_be", {28'h0, data_be_o}, 32'h0);
    check("rst_wdata", data_wdata_o, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_misal", {31'h0, misalign_o}, 32'h0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    do_access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 2, 0, 32'h0);
    do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 2, 32'h80112233);
    do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 2, 32'h80112233);
    do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 1, 0, 32'h0);
    do_access(1'b1, 1'b0, 3'b001, 32'h300, 32'h0, 0, 0, 32'h7FFF8001);
    do_access(1'b1, 1'b1, 3'b010, 32'h40, 32'h55AA55AA, 0, 0, 32'h0);
    do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 1, 32'h11223344);
    do_access(1'b1, 1'b0, 3'b101, 32'h3, 32'h0, 1, 1, 32'hCAFE8765);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 2);
      do_access(sel != 1, sel != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // Reset while waiting in RESP; the late rvalid must be dropped.
    memrd_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h500;
    @(posedge clk); #1;
    data_gnt_i = 1'b1;
    @(posedge clk); #1;
    data_gnt_i = 1'b0;
    check("rr_resp_stall", {31'h0, stall_o}, 32'h1);
    rst_ni = 1'b0; memrd_i = 1'b0;
    #1;
    check("rr_req", {31'h0, data_req_o}, 32'h0);
    check("rr_we", {31'h0, data_we_o}, 32'h0);
    check("rr_addr", data_addr_o, 32'h0);
    check("rr_be", {28'h0, data_be_o}, 32'h0);
    check("rr_wdata", data_wdata_o, 32'h0);
    check("rr_rdata", rdata_o, 32'h0);
    check("rr_stall", {31'h0, stall_o}, 32'h0);
    data_rvalid_i = 1'b1; data_rdata_i = 32'h12345678;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("rr_late_rdata", rdata_o, 32'h0);
    check("rr_late_stall", {31'h0, stall_o}, 32'h0);
    check("rr_late_req", {31'h0, data_req_o}, 32'h0);
    data_rvalid_i = 1'b0;
    @(posedge clk); #1;
    check("rr_idle_rdata", rdata_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
